// File: rtl/mssd_pkg.sv
// mssd_pkg: shared entry type and widths for the serial splitter datapath.
package mssd_pkg;
    localparam int PORT_W = 2;
    localparam int BYTE_W = 8;
    typedef struct packed {
        logic              last;
        logic [PORT_W-1:0] port;
        logic [BYTE_W-1:0] data;
    } mssd_entry_t;
endpackage

// File: rtl/mssd_sync_fifo.sv
// mssd_sync_fifo: count-based synchronous FIFO; a push into a full FIFO is taken when a pop frees the slot.
module mssd_sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic [AW:0] count;
    logic wr_en, rd_en;
    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign rdata = empty ? '0 : mem[rd];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            rd    <= rd + AW'(rd_en);
            wr    <= wr + AW'(wr_en);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr] <= wdata;
    end
endmodule

// File: rtl/mssd_byte_collector.sv
// mssd_byte_collector: assembles the active port's serial bits MSB-first into bytes and
// queues them with port and end-of-frame tags for a valid/ready consumer.
module mssd_byte_collector
    import mssd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = BYTE_W
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              serEn,
    input  logic              frameEnd,
    input  logic [1:0]        portNum,
    input  logic              P0,
    input  logic              P1,
    input  logic              P2,
    input  logic              P3,
    input  logic              outReady,
    input  logic              clrErr,
    output logic              outValid,
    output logic [DATA_W-1:0] outData,
    output logic [1:0]        outPort,
    output logic              outLast,
    output logic              overflow,
    output logic              fragErr
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    logic [3:0] lines;
    logic [DATA_W-1:0] shift, shifted;
    logic [CW-1:0] bit_cnt;
    logic bit_in, last_bit, push, pop, full, empty, ovf_set, frag_set;
    mssd_entry_t wr_entry, rd_entry;
    assign lines    = {P3, P2, P1, P0};
    assign bit_in   = lines[portNum];
    assign shifted  = {shift[DATA_W-2:0], bit_in};
    assign last_bit = bit_cnt == LAST;
    assign push     = serEn & (last_bit | frameEnd);
    assign pop      = outValid & outReady;
    assign ovf_set  = push & full & ~pop;
    assign frag_set = serEn & frameEnd & ~last_bit;
    // A short final byte is left-aligned so its first bit lands in the MSB.
    assign wr_entry = '{last: frameEnd, port: portNum,
                        data: last_bit ? shifted : shifted << (LAST - bit_cnt)};
    mssd_sync_fifo #(.WIDTH($bits(mssd_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (Clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .empty (empty),
        .full  (full)
    );
    assign outValid = ~empty;
    assign outData  = rd_entry.data;
    assign outPort  = rd_entry.port;
    assign outLast  = rd_entry.last;
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            shift    <= '0;
            bit_cnt  <= '0;
            overflow <= 1'b0;
            fragErr  <= 1'b0;
        end else begin
            if (serEn) begin
                shift   <= shifted;
                bit_cnt <= push ? '0 : bit_cnt + 1'b1;
            end
            overflow <= ovf_set | (overflow & ~clrErr);
            fragErr  <= frag_set | (fragErr & ~clrErr);
        end
    end
endmodule

// File: tb/tb_mssd_byte_collector.sv
// tb_mssd_byte_collector: directed checks of byte assembly, FIFO back-pressure, error flags and reset.
module tb_mssd_byte_collector;
    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic       serEn = 1'b0, frameEnd = 1'b0, outReady = 1'b0, clrErr = 1'b0;
    logic [1:0] portNum = 2'd0;
    logic       P0 = 1'b0, P1 = 1'b0, P2 = 1'b0, P3 = 1'b0;
    logic       outValid, outLast, overflow, fragErr;
    logic [7:0] outData;
    logic [1:0] outPort;
    int n_checks = 0;
    int n_fail = 0;

    mssd_byte_collector dut (
        .Clk(Clk), .reset(reset), .serEn(serEn), .frameEnd(frameEnd), .portNum(portNum),
        .P0(P0), .P1(P1), .P2(P2), .P3(P3), .outReady(outReady), .clrErr(clrErr),
        .outValid(outValid), .outData(outData), .outPort(outPort), .outLast(outLast),
        .overflow(overflow), .fragErr(fragErr)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Active line carries b; the other three lines get noise.
    task automatic bit_step(input logic b, input logic fe);
        logic [3:0] p;
        p = 4'($urandom);
        p[portNum] = b;
        {P3, P2, P1, P0} = p;
        serEn = 1'b1;
        frameEnd = fe;
        tick();
        serEn = 1'b0;
        frameEnd = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n, input logic fe);
        for (int i = n - 1; i >= 0; i--) bit_step(v[i], fe && i == 0);
    endtask

    task automatic head(input string tag, input logic [7:0] d, input logic [1:0] p, input logic l);
        check({tag, "_valid"}, 32'(outValid), 32'd1);
        check({tag, "_data"}, 32'(outData), 32'(d));
        check({tag, "_port"}, 32'(outPort), 32'(p));
        check({tag, "_last"}, 32'(outLast), 32'(l));
    endtask

    initial begin
        logic [7:0] v;
        repeat (2) tick();
        check("rst_valid", 32'(outValid), 32'd0);
        check("rst_data", 32'(outData), 32'd0);
        check("rst_port", 32'(outPort), 32'd0);
        check("rst_last", 32'(outLast), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_frag", 32'(fragErr), 32'd0);
        reset = 1'b1;
        tick();

        // 1: two-byte frame on P2, consumer always ready
        portNum = 2'd2;
        outReady = 1'b1;
        send_bits(8'hA5, 8, 1'b0);
        head("t1_b0", 8'hA5, 2'd2, 1'b0);
        send_bits(8'h3C, 8, 1'b1);
        head("t1_b1", 8'h3C, 2'd2, 1'b1);
        tick();
        check("t1_empty", 32'(outValid), 32'd0);
        check("t1_frag", 32'(fragErr), 32'd0);

        // 2: five bytes with consumer stalled; fifth is dropped
        portNum = 2'd0;
        outReady = 1'b0;
        send_bits(8'h11, 8, 1'b0);
        head("t2_b1", 8'h11, 2'd0, 1'b0);
        send_bits(8'h22, 8, 1'b0);
        send_bits(8'h33, 8, 1'b0);
        send_bits(8'h44, 8, 1'b0);
        check("t2_ovf_full", 32'(overflow), 32'd0);
        send_bits(8'h55, 8, 1'b0);
        check("t2_ovf_set", 32'(overflow), 32'd1);
        check("t2_head", 32'(outData), 32'h11);
        clrErr = 1'b1;
        tick();
        clrErr = 1'b0;
        check("t2_ovf_clr", 32'(overflow), 32'd0);

        // 3: byte completes on a full FIFO in the same cycle as a pop
        v = 8'h66;
        for (int i = 7; i >= 1; i--) bit_step(v[i], 1'b0);
        outReady = 1'b1;
        bit_step(v[0], 1'b0);
        outReady = 1'b0;
        check("t3_ovf", 32'(overflow), 32'd0);
        head("t3_h0", 8'h22, 2'd0, 1'b0);
        outReady = 1'b1;
        tick();
        head("t3_h1", 8'h33, 2'd0, 1'b0);
        tick();
        head("t3_h2", 8'h44, 2'd0, 1'b0);
        tick();
        head("t3_h3", 8'h66, 2'd0, 1'b0);
        tick();
        check("t3_empty", 32'(outValid), 32'd0);

        // 4: 12-bit frame on P1 leaves a zero-padded partial byte
        portNum = 2'd1;
        outReady = 1'b0;
        send_bits(8'hFF, 8, 1'b0);
        send_bits(8'h0F, 4, 1'b1);
        check("t4_frag", 32'(fragErr), 32'd1);
        head("t4_h0", 8'hFF, 2'd1, 1'b0);
        outReady = 1'b1;
        tick();
        head("t4_h1", 8'hF0, 2'd1, 1'b1);
        tick();
        check("t4_empty", 32'(outValid), 32'd0);
        clrErr = 1'b1;
        tick();
        clrErr = 1'b0;
        check("t4_frag_clr", 32'(fragErr), 32'd0);

        // 5: three idle cycles with noisy lines between each bit of 0x81
        portNum = 2'd0;
        outReady = 1'b0;
        v = 8'h81;
        for (int i = 7; i >= 0; i--) begin
            bit_step(v[i], 1'b0);
            if (i != 0) begin
                for (int k = 0; k < 3; k++) begin
                    {P3, P2, P1, P0} = 4'($urandom);
                    tick();
                end
            end
        end
        head("t5", 8'h81, 2'd0, 1'b0);
        outReady = 1'b1;
        tick();
        check("t5_empty", 32'(outValid), 32'd0);

        // 6: async reset with two entries queued and five bits in flight
        portNum = 2'd3;
        outReady = 1'b0;
        send_bits(8'h12, 8, 1'b0);
        send_bits(8'h34, 8, 1'b0);
        send_bits(8'h16, 5, 1'b0);
        head("t6_pre", 8'h12, 2'd3, 1'b0);
        reset = 1'b0;
        #1;
        check("t6_rst_valid", 32'(outValid), 32'd0);
        check("t6_rst_data", 32'(outData), 32'd0);
        check("t6_rst_port", 32'(outPort), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        send_bits(8'hC3, 8, 1'b0);
        head("t6_post", 8'hC3, 2'd3, 1'b0);
        tick();
        check("t6_post_hold", 32'(outData), 32'hC3);
        check("t6_ovf", 32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
